// File: rtl/match_req_dispatcher_if.sv
// Batch-in / per-channel-out bus of the match-request dispatcher, plus the
// bound-programming port and status.
interface match_req_dispatcher_if #(
   parameter int LANES       = 4,
   parameter int NUM_CH      = 4,
   parameter int OFFSET_BITS = 20,
   parameter int TAG_BITS    = 8
);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                                  in_valid;
   logic                                  in_ready;
   logic [LANES-1:0]                      in_lane_valid;
   logic [LANES-1:0][OFFSET_BITS-1:0]     in_offset;
   logic [LANES-1:0][TAG_BITS-1:0]        in_tag;

   logic [NUM_CH-1:0]                     out_valid;
   logic [NUM_CH-1:0]                     out_ready;
   logic [NUM_CH-1:0][OFFSET_BITS-1:0]    out_offset;
   logic [NUM_CH-1:0][TAG_BITS-1:0]       out_tag;
   logic [NUM_CH-1:0][LANE_W-1:0]         out_lane;

   logic                                  cfg_we;
   logic [CH_W-1:0]                       cfg_ch;
   logic                                  cfg_sel;
   logic [OFFSET_BITS-1:0]                cfg_data;

   logic [15:0]                           drop_cnt;
   logic                                  busy;

   modport master (
      output in_valid, in_lane_valid, in_offset, in_tag, out_ready,
             cfg_we, cfg_ch, cfg_sel, cfg_data,
      input  in_ready, out_valid, out_offset, out_tag, out_lane, drop_cnt, busy
   );

   modport slave (
      input  in_valid, in_lane_valid, in_offset, in_tag, out_ready,
             cfg_we, cfg_ch, cfg_sel, cfg_data,
      output in_ready, out_valid, out_offset, out_tag, out_lane, drop_cnt, busy
   );
endinterface

// File: rtl/match_req_dispatcher.sv
// Routes a batch of lazy-match requests to PE channels by programmable offset
// windows, then drains each channel with its own valid/ready handshake.
module mrd_lane_route #(
   parameter int NUM_CH      = 4,
   parameter int OFFSET_BITS = 20,
   parameter int ROUTE_MODE  = 0
) (
   input  logic                               vld_i,
   input  logic [OFFSET_BITS-1:0]             off_i,
   input  logic [NUM_CH-1:0][OFFSET_BITS-1:0] lower_i,
   input  logic [NUM_CH-1:0][OFFSET_BITS-1:0] upper_i,
   output logic [NUM_CH-1:0]                  route_o,
   output logic                               drop_o
);
   logic [NUM_CH-1:0] hit;

   // An inverted window (upper <= lower) can never satisfy both compares.
   always_comb begin
      for (int j = 0; j < NUM_CH; j++)
         hit[j] = vld_i && (off_i >= lower_i[j]) && (off_i < upper_i[j]);
   end

   assign route_o = (ROUTE_MODE != 0) ? hit : (hit & (~hit + NUM_CH'(1)));
   assign drop_o  = vld_i && (hit == '0);
endmodule

module match_req_dispatcher #(
   parameter int LANES       = 4,
   parameter int NUM_CH      = 4,
   parameter int OFFSET_BITS = 20,
   parameter int TAG_BITS    = 8,
   parameter int BASE_LOG2   = 14,
   parameter int MARGIN      = 768,
   parameter int ROUTE_MODE  = 0
) (
   input logic                   clk,
   input logic                   rst_n,
   match_req_dispatcher_if.slave bus
);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic {IDLE, DISPATCH} state_e;

   state_e                             state_q;
   logic [NUM_CH-1:0][OFFSET_BITS-1:0] lower_q, upper_q;
   logic [LANES-1:0][OFFSET_BITS-1:0]  off_q;
   logic [LANES-1:0][TAG_BITS-1:0]     tag_q;
   logic [LANES-1:0][NUM_CH-1:0]       pend_q, pend_d, route;
   logic [LANES-1:0]                   drop_lane;
   logic [15:0]                        drop_q, drop_d;
   logic [16:0]                        drop_sum;
   logic [NUM_CH-1:0][LANE_W-1:0]      sel;
   logic [NUM_CH-1:0]                  ch_vld, fire;
   logic [NUM_CH-1:0][OFFSET_BITS-1:0] out_off;
   logic [NUM_CH-1:0][TAG_BITS-1:0]    out_tg;
   logic [NUM_CH-1:0][LANE_W-1:0]      out_ln;

   function automatic logic [OFFSET_BITS-1:0] rst_upper(input int j);
      logic [63:0] v;
      v = (64'd1 << (BASE_LOG2 + j)) - 64'(MARGIN);
      return v[OFFSET_BITS-1:0];
   endfunction

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mrd_lane_route #(
         .NUM_CH      (NUM_CH),
         .OFFSET_BITS (OFFSET_BITS),
         .ROUTE_MODE  (ROUTE_MODE)
      ) u_route (
         .vld_i   (bus.in_lane_valid[i]),
         .off_i   (bus.in_offset[i]),
         .lower_i (lower_q),
         .upper_i (upper_q),
         .route_o (route[i]),
         .drop_o  (drop_lane[i])
      );
   end

   // Each channel serves its lowest pending lane; scan downward so the lowest wins.
   always_comb begin
      for (int j = 0; j < NUM_CH; j++) begin
         sel[j]    = '0;
         ch_vld[j] = 1'b0;
         for (int i = LANES - 1; i >= 0; i--) begin
            if (pend_q[i][j]) begin
               sel[j]    = LANE_W'(i);
               ch_vld[j] = 1'b1;
            end
         end
      end
   end

   assign fire = ch_vld & bus.out_ready;

   always_comb begin
      pend_d = pend_q;
      for (int j = 0; j < NUM_CH; j++)
         if (fire[j]) pend_d[sel[j]][j] = 1'b0;
   end

   always_comb begin
      drop_sum = {1'b0, drop_q};
      for (int i = 0; i < LANES; i++)
         drop_sum = drop_sum + 17'(drop_lane[i]);
      drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_comb begin
      for (int j = 0; j < NUM_CH; j++) begin
         out_off[j] = ch_vld[j] ? off_q[sel[j]] : '0;
         out_tg[j]  = ch_vld[j] ? tag_q[sel[j]] : '0;
         out_ln[j]  = ch_vld[j] ? sel[j]        : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         off_q   <= '0;
         tag_q   <= '0;
         drop_q  <= '0;
         lower_q <= '0;
         for (int j = 0; j < NUM_CH; j++) upper_q[j] <= rst_upper(j);
      end else begin
         // Bounds only feed routing at accept, so in-flight batches ignore writes.
         if (bus.cfg_we) begin
            if (bus.cfg_sel) upper_q[bus.cfg_ch] <= bus.cfg_data;
            else             lower_q[bus.cfg_ch] <= bus.cfg_data;
         end
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  off_q  <= bus.in_offset;
                  tag_q  <= bus.in_tag;
                  pend_q <= route;
                  drop_q <= drop_d;
                  if (route != '0) state_q <= DISPATCH;
               end
            end
            DISPATCH: begin
               pend_q <= pend_d;
               if (pend_d == '0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.busy       = (state_q == DISPATCH);
   assign bus.out_valid  = ch_vld;
   assign bus.out_offset = out_off;
   assign bus.out_tag    = out_tg;
   assign bus.out_lane   = out_ln;
   assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_match_req_dispatcher.sv
// Scoreboard bench: routing model for first-match mode feeds per-channel
// expected queues; a second instance exercises broadcast mode.
module tb_match_req_dispatcher;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   match_req_dispatcher_if #(.LANES(4), .NUM_CH(4), .OFFSET_BITS(20), .TAG_BITS(8)) bus0 ();
   match_req_dispatcher_if #(.LANES(4), .NUM_CH(4), .OFFSET_BITS(20), .TAG_BITS(8)) bus1 ();

   match_req_dispatcher #(.ROUTE_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   match_req_dispatcher #(.ROUTE_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      logic [1:0]  lane;
      logic [19:0] off;
      logic [7:0]  tag;
   } exp_t;

   exp_t        exp_q [4][$];
   logic [19:0] lo_m [4];
   logic [19:0] up_m [4];
   int unsigned drop_m;
   int          checks = 0;
   int          errors = 0;

   task automatic reset_models();
      for (int j = 0; j < 4; j++) begin
         lo_m[j] = 20'd0;
         up_m[j] = 20'((1 << (14 + j)) - 768);
         exp_q[j].delete();
      end
      drop_m = 0;
   endtask

   task automatic idle_inputs();
      bus0.in_valid = 0; bus0.in_lane_valid = '0; bus0.in_offset = '0; bus0.in_tag = '0;
      bus0.out_ready = '0; bus0.cfg_we = 0; bus0.cfg_ch = '0; bus0.cfg_sel = 0; bus0.cfg_data = '0;
      bus1.in_valid = 0; bus1.in_lane_valid = '0; bus1.in_offset = '0; bus1.in_tag = '0;
      bus1.out_ready = '0; bus1.cfg_we = 0; bus1.cfg_ch = '0; bus1.cfg_sel = 0; bus1.cfg_data = '0;
   endtask

   // Drive one batch for one cycle and push the first-match expectations.
   task automatic send_batch(input logic [3:0] lv, input logic [3:0][19:0] off,
                             input logic [3:0][7:0] tg);
      int   nd;
      bit   hit;
      exp_t e;
      bus0.in_valid = 1; bus0.in_lane_valid = lv; bus0.in_offset = off; bus0.in_tag = tg;
      checks++;
      if (bus0.in_ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready got %b want 1", bus0.in_ready);
      end
      nd = 0;
      for (int i = 0; i < 4; i++) begin
         if (lv[i]) begin
            hit = 0;
            for (int j = 0; j < 4; j++) begin
               if (!hit && off[i] >= lo_m[j] && off[i] < up_m[j]) begin
                  e.lane = 2'(i); e.off = off[i]; e.tag = tg[i];
                  exp_q[j].push_back(e);
                  hit = 1;
               end
            end
            if (!hit) nd++;
         end
      end
      drop_m = (drop_m + nd > 65535) ? 65535 : drop_m + nd;
      @(posedge clk); #1;
      bus0.in_valid = 0; bus0.in_lane_valid = '0; bus0.cfg_we = 0;
   endtask

   task automatic cfg_write(input int ch, input bit sel, input logic [19:0] val);
      bus0.cfg_we = 1; bus0.cfg_ch = 2'(ch); bus0.cfg_sel = sel; bus0.cfg_data = val;
      @(posedge clk); #1;
      bus0.cfg_we = 0;
      if (sel) up_m[ch] = val; else lo_m[ch] = val;
   endtask

   // Pop/compare per channel each cycle until the batch is drained and idle.
   task automatic drain(input string name, input int stall0, input logic [3:0] rdy,
                        input int budget, output int busy_n);
      int   cyc;
      bit   empty;
      exp_t e;
      cyc = 0; busy_n = 0;
      forever begin
         empty = 1;
         bus0.out_ready = rdy;
         if (cyc < stall0) bus0.out_ready[0] = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (exp_q[j].size() != 0) empty = 0;
            checks++;
            if (bus0.out_valid[j] !== (exp_q[j].size() != 0)) begin
               errors++;
               $display("FAIL %s ch%0d valid cyc %0d got %b want %b", name, j, cyc,
                        bus0.out_valid[j], exp_q[j].size() != 0);
            end
            if (bus0.out_valid[j] === 1'b1 && exp_q[j].size() != 0) begin
               e = exp_q[j][0];
               checks++;
               if (bus0.out_lane[j] !== e.lane || bus0.out_offset[j] !== e.off ||
                   bus0.out_tag[j] !== e.tag) begin
                  errors++;
                  $display("FAIL %s ch%0d payload got lane %0d off %0d tag %h want lane %0d off %0d tag %h",
                           name, j, bus0.out_lane[j], bus0.out_offset[j], bus0.out_tag[j],
                           e.lane, e.off, e.tag);
               end
               if (bus0.out_ready[j]) void'(exp_q[j].pop_front());
            end
         end
         if (bus0.busy === 1'b1) busy_n++;
         if (empty && bus0.busy !== 1'b1) break;
         if (cyc >= budget) begin
            errors++; $display("FAIL %s timeout after %0d cycles", name, cyc);
            for (int j = 0; j < 4; j++) exp_q[j].delete();
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (bus0.in_ready !== 1'b1) begin
         errors++; $display("FAIL %s in_ready_after got %b want 1", name, bus0.in_ready);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 4'b0 || bus0.busy !== 1'b0 ||
          bus0.drop_cnt !== 16'd0 || bus0.out_offset !== '0 || bus0.out_tag !== '0 ||
          bus0.out_lane !== '0) begin
         errors++;
         $display("FAIL reset_state got rdy %b vld %b busy %b drop %0d", bus0.in_ready,
                  bus0.out_valid, bus0.busy, bus0.drop_cnt);
      end
      checks++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 4'b0 || bus1.busy !== 1'b0) begin
         errors++; $display("FAIL reset_state_bc got rdy %b vld %b", bus1.in_ready, bus1.out_valid);
      end
   endtask

   task automatic test_reset_routing();
      int b;
      send_batch(4'b1111, {20'd900000, 20'd40000, 20'd20000, 20'd100},
                 {8'h13, 8'h12, 8'h11, 8'h10});
      drain("reset_routing", 0, 4'hF, 20, b);
      checks++;
      if (b !== 1) begin errors++; $display("FAIL reset_routing busy_cycles got %0d want 1", b); end
      checks++;
      if (bus0.drop_cnt !== 16'd1) begin
         errors++; $display("FAIL reset_routing drop got %0d want 1", bus0.drop_cnt);
      end
   endtask

   // ch3 is moved above 100 first so only ch0..ch2 contain offset 100.
   task automatic test_broadcast();
      bus1.cfg_we = 1; bus1.cfg_ch = 2'd3; bus1.cfg_sel = 0; bus1.cfg_data = 20'd64768;
      @(posedge clk); #1;
      bus1.cfg_we = 0; bus1.out_ready = 4'hF;
      bus1.in_valid = 1; bus1.in_lane_valid = 4'b0001;
      bus1.in_offset = {20'd0, 20'd0, 20'd0, 20'd100}; bus1.in_tag = {8'h0, 8'h0, 8'h0, 8'h5A};
      @(posedge clk); #1;
      bus1.in_valid = 0; bus1.in_lane_valid = '0;
      checks++;
      if (bus1.out_valid !== 4'b0111) begin
         errors++; $display("FAIL broadcast valid got %b want 0111", bus1.out_valid);
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (bus1.out_lane[j] !== 2'd0 || bus1.out_offset[j] !== 20'd100 || bus1.out_tag[j] !== 8'h5A) begin
            errors++;
            $display("FAIL broadcast ch%0d payload got lane %0d off %0d tag %h want 0 100 5a",
                     j, bus1.out_lane[j], bus1.out_offset[j], bus1.out_tag[j]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (bus1.out_valid !== 4'b0 || bus1.in_ready !== 1'b1) begin
         errors++; $display("FAIL broadcast done got vld %b rdy %b want 0000 1",
                            bus1.out_valid, bus1.in_ready);
      end
      bus1.out_ready = '0;
   endtask

   task automatic test_conflict();
      int b;
      send_batch(4'b0111, {20'd0, 20'd30, 20'd20, 20'd10}, {8'h0, 8'h22, 8'h21, 8'h20});
      drain("conflict", 2, 4'hF, 20, b);
      checks++;
      if (b !== 5) begin errors++; $display("FAIL conflict busy_cycles got %0d want 5", b); end
   endtask

   task automatic test_reprogram();
      int b;
      bus0.out_ready = '0;
      bus0.cfg_we = 1; bus0.cfg_ch = 2'd3; bus0.cfg_sel = 1; bus0.cfg_data = 20'hFFFFF;
      send_batch(4'b0011, {20'd0, 20'd0, 20'd100, 20'd900000}, {8'h0, 8'h0, 8'h31, 8'h30});
      up_m[3] = 20'hFFFFF;
      cfg_write(3, 0, 20'd0);
      drain("reprogram_inflight", 0, 4'hF, 20, b);
      checks++;
      if (bus0.drop_cnt !== 16'(drop_m)) begin
         errors++; $display("FAIL reprogram_inflight drop got %0d want %0d", bus0.drop_cnt, drop_m);
      end
      send_batch(4'b0001, {20'd0, 20'd0, 20'd0, 20'd900000}, {8'h0, 8'h0, 8'h0, 8'h40});
      drain("reprogram_next", 0, 4'hF, 20, b);
      checks++;
      if (bus0.drop_cnt !== 16'(drop_m)) begin
         errors++; $display("FAIL reprogram_next drop got %0d want %0d", bus0.drop_cnt, drop_m);
      end
   endtask

   task automatic test_empty_unroutable();
      int b;
      send_batch(4'b0000, {20'd100, 20'd100, 20'd100, 20'd100}, '0);
      drain("empty", 0, 4'hF, 5, b);
      checks++;
      if (b !== 0) begin errors++; $display("FAIL empty busy_cycles got %0d want 0", b); end
      for (int n = 0; n < 16385; n++) begin
         send_batch(4'b1111, {4{20'hFFFFF}}, {8'h3, 8'h2, 8'h1, 8'h0});
         if (n == 100) begin
            checks++;
            if (bus0.drop_cnt !== 16'(drop_m)) begin
               errors++; $display("FAIL unroutable_mid drop got %0d want %0d", bus0.drop_cnt, drop_m);
            end
         end
      end
      drain("unroutable", 0, 4'hF, 5, b);
      checks++;
      if (bus0.drop_cnt !== 16'hFFFF || drop_m != 65535) begin
         errors++; $display("FAIL drop_saturate got %0d want 65535", bus0.drop_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int b;
      bus0.out_ready = '0;
      send_batch(4'b0001, {20'd0, 20'd0, 20'd0, 20'd20000}, {8'h0, 8'h0, 8'h0, 8'h50});
      checks++;
      if (bus0.out_valid !== 4'b0010) begin
         errors++; $display("FAIL reset_mid stalled got %b want 0010", bus0.out_valid);
      end
      rst_n = 0;
      #1;
      checks++;
      if (bus0.out_valid !== 4'b0 || bus0.in_ready !== 1'b1 || bus0.busy !== 1'b0 ||
          bus0.drop_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_mid got vld %b rdy %b busy %b drop %0d want 0000 1 0 0",
                            bus0.out_valid, bus0.in_ready, bus0.busy, bus0.drop_cnt);
      end
      reset_models();
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      // 900000 must drop again and 100000 must land in the default ch3 window.
      send_batch(4'b0111, {20'd0, 20'd100000, 20'd20000, 20'd900000}, {8'h0, 8'h62, 8'h61, 8'h60});
      drain("reset_defaults", 0, 4'hF, 20, b);
      checks++;
      if (bus0.drop_cnt !== 16'd1) begin
         errors++; $display("FAIL reset_defaults drop got %0d want 1", bus0.drop_cnt);
      end
   endtask

   initial begin
      idle_inputs();
      reset_models();
      #12;
      test_reset();
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      test_reset_routing();
      test_broadcast();
      test_conflict();
      test_reprogram();
      test_empty_unroutable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
